// File: rtl/echo_delay_scheduler.sv
// Echo delay-line scheduler: per codec sample it reads the delayed sample, mixes an attenuated copy in, writes the mix back.
// Latency 4 cycles from new_sample_ready to sample_valid; pulses arriving while busy are dropped and flagged on overrun.
module echo_delay_scheduler #(
  parameter int ADDR_W      = 12,
  parameter int DATA_W      = 16,
  parameter int ATTEN_SHIFT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              new_sample_ready,
  input  logic [DATA_W-1:0] sample_in,
  input  logic              echo_enable,
  input  logic [ADDR_W-1:0] delay_len,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic [DATA_W-1:0] sample_to_codec,
  output logic              sample_valid,
  output logic              busy,
  output logic              overrun
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_WAIT  = 2'd2,
    S_WRITE = 2'd3
  } state_t;

  localparam logic [DATA_W-1:0] SAT_MAX = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0] SAT_MIN = {1'b1, {(DATA_W-1){1'b0}}};

  state_t              r_state;
  logic [ADDR_W-1:0]   r_wr_ptr;
  logic [ADDR_W-1:0]   r_delay_q;
  logic [ADDR_W:0]     r_fill_cnt;
  logic [DATA_W-1:0]   r_s;
  logic [DATA_W-1:0]   r_mix;
  logic [ADDR_W-1:0]   r_ram_addr;
  logic                r_ram_we;
  logic [DATA_W-1:0]   r_out;
  logic                r_valid;
  logic                r_overrun;

  logic [ADDR_W-1:0]        w_rd_ptr;
  logic [ADDR_W:0]          w_delay_ext;
  logic                     w_fill_ok;
  logic [ADDR_W:0]          w_fill_inc;
  logic [ADDR_W:0]          w_fill_next;
  logic [DATA_W-1:0]        w_echo;
  logic signed [DATA_W-1:0] w_echo_sh;
  logic [DATA_W:0]          w_sum;
  logic [DATA_W-1:0]        w_mix_sat;
  logic [DATA_W-1:0]        w_out_sel;

  assign w_rd_ptr    = r_wr_ptr - r_delay_q;
  assign w_delay_ext = {1'b0, r_delay_q};

  // A location only counts as echo once it has been written under the current delay.
  assign w_fill_ok   = (r_fill_cnt >= w_delay_ext) && (r_delay_q != '0);
  assign w_fill_inc  = r_fill_cnt + {{ADDR_W{1'b0}}, 1'b1};
  assign w_fill_next = (w_fill_inc > w_delay_ext) ? w_delay_ext : w_fill_inc;

  assign w_echo    = w_fill_ok ? ram_rdata : '0;
  assign w_echo_sh = $signed(w_echo) >>> ATTEN_SHIFT;
  assign w_sum     = {w_echo_sh[DATA_W-1], w_echo_sh} + {r_s[DATA_W-1], r_s};

  // Overflow shows as disagreement between the two top bits of the widened sum.
  always_comb begin
    w_mix_sat = w_sum[DATA_W-1:0];
    if (w_sum[DATA_W] != w_sum[DATA_W-1]) begin
      w_mix_sat = w_sum[DATA_W] ? SAT_MIN : SAT_MAX;
    end
  end

  // echo_enable is looked at only while writing, so it may change freely mid-sample.
  assign w_out_sel = echo_enable ? r_mix : r_s;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_wr_ptr   <= '0;
      r_delay_q  <= delay_len;
      r_fill_cnt <= '0;
      r_s        <= '0;
      r_mix      <= '0;
      r_ram_addr <= '0;
      r_ram_we   <= 1'b0;
      r_out      <= '0;
      r_valid    <= 1'b0;
      r_overrun  <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      if (new_sample_ready && (r_state != S_IDLE)) begin
        r_overrun <= 1'b1;
      end
      case (r_state)
        S_IDLE: begin
          r_ram_addr <= '0;
          r_ram_we   <= 1'b0;
          if (new_sample_ready) begin
            r_s        <= sample_in;
            r_ram_addr <= w_rd_ptr;
            r_state    <= S_READ;
          end else if (delay_len != r_delay_q) begin
            r_delay_q  <= delay_len;
            r_fill_cnt <= '0;
          end
        end
        S_READ: begin
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          r_mix      <= w_mix_sat;
          r_ram_addr <= r_wr_ptr;
          r_ram_we   <= 1'b1;
          r_state    <= S_WRITE;
        end
        S_WRITE: begin
          r_out      <= w_out_sel;
          r_valid    <= 1'b1;
          r_wr_ptr   <= r_wr_ptr + 1'b1;
          r_fill_cnt <= w_fill_next;
          r_ram_addr <= '0;
          r_ram_we   <= 1'b0;
          r_state    <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign ram_addr        = r_ram_addr;
  assign ram_we          = r_ram_we;
  assign ram_wdata       = (r_state == S_WRITE) ? w_out_sel : '0;
  assign sample_to_codec = r_out;
  assign sample_valid    = r_valid;
  assign busy            = (r_state != S_IDLE);
  assign overrun         = r_overrun;

endmodule

// File: doc/echo_delay_scheduler.md
Name: echo_delay_scheduler

Overview:
Sequences the echo effect's single-port delay-line RAM once per codec sample: reads the delayed sample, mixes an attenuated copy into the incoming sample, writes the mixed result back, and presents the output to the codec. It sits between the sample source (sample_in/new_sample_ready) and the codec output, replacing ad-hoc address counting with one scheduler that owns all RAM address, write-enable and fill-tracking decisions. Feedback writes (the mix, not the dry sample) produce repeating, decaying echoes.

Parameters:
ADDR_W, 12, delay-line RAM address width; depth = 2^ADDR_W samples
DATA_W, 16, sample width, two's complement
ATTEN_SHIFT, 1, echo gain = 2^-ATTEN_SHIFT (arithmetic right shift)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
new_sample_ready  in  1  one-cycle pulse, sample_in valid this cycle
sample_in  in  DATA_W  signed incoming sample
echo_enable  in  1  1 = mix echo into output, 0 = dry passthrough
delay_len  in  ADDR_W  echo delay in samples
ram_addr  out  ADDR_W  RAM address
ram_we  out  1  RAM write enable
ram_wdata  out  DATA_W  RAM write data
ram_rdata  in  DATA_W  RAM read data, valid the cycle after a read address is presented
sample_to_codec  out  DATA_W  registered output sample
sample_valid  out  1  one-cycle pulse, sample_to_codec updated
busy  out  1  high in any state other than IDLE
overrun  out  1  sticky: sample pulse dropped while busy

Behaviour:
- Reset (sync, wins over everything, including mid-operation): state IDLE; sample_to_codec=0, sample_valid=0, overrun=0, ram_we=0, ram_addr=0, ram_wdata=0; wr_ptr=0; fill_cnt=0; delay_q<=delay_len. RAM contents are not cleared; fill_cnt guards stale data.
- FSM IDLE -> READ -> WAIT -> WRITE -> IDLE, one cycle per state except IDLE.
- IDLE, new_sample_ready=1 at cycle N: s_reg<=sample_in; go READ.
- READ (N+1): ram_addr=rd_ptr=(wr_ptr-delay_q) mod 2^ADDR_W, ram_we=0.
- WAIT (N+2): echo = (fill_cnt>=delay_q && delay_q!=0) ? ram_rdata : 0; mix_reg <= sat(s_reg + (echo >>> ATTEN_SHIFT)). Sum computed at DATA_W+1 bits, clamped to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
- WRITE (N+3): ram_addr=wr_ptr, ram_we=1, ram_wdata = echo_enable ? mix_reg : s_reg. At the edge: sample_to_codec <= same value; sample_valid<=1; wr_ptr<=wr_ptr+1 (wraps 2^ADDR_W-1 -> 0); fill_cnt<=min(fill_cnt+1, delay_q).
- sample_valid high during cycle N+4 only; latency 4 cycles. A new pulse in cycle N+4 (back in IDLE) is accepted. Minimum pulse spacing 4 cycles.
- ram_we is 1 only in WRITE; ram_addr/ram_wdata hold 0 in IDLE.
- new_sample_ready while busy: pulse dropped, overrun<=1 until reset; in-flight sample completes unaffected.
- Delay change: in IDLE with no pulse, if delay_len!=delay_q then delay_q<=delay_len, fill_cnt<=0. The change is applied only in IDLE; if a pulse and a delay change coincide, the pulse is accepted and the change is applied on a later IDLE cycle.
- delay_q==0: echo forced to 0, output = s_reg (saturation not triggered); writes continue.
- fill_cnt is ADDR_W+1 bits and saturates at delay_q; no echo is taken from a location not written since reset or since the last delay change.
- echo_enable is sampled in WRITE only; toggling it mid-sample is legal.

Test Plan:
1. Reset for 2 cycles, then idle 10 cycles -> all outputs 0, busy=0, ram_we never 1.
2. delay_len=3, enable=1, samples 100,200,300,400,500,0,0, pulses 6 cycles apart -> outputs 100,200,300,450,600,150,225 (feedback); each sample_valid lands exactly 4 cycles after its pulse.
3. delay_len=1: inputs 30000,30000 -> 30000,32767; after reset, -30000,-30000 -> -30000,-32768.
4. echo_enable=0, delay 2, inputs 10,20,30 -> outputs 10,20,30 with RAM writes 10,20,30; re-enable, input 0 -> output 10 (echo of 20 >>> 1).
5. Pulses 2 cycles apart -> second pulse dropped, one sample_valid, overrun=1 held until reset.
6. delay 2, run 3 samples, set delay_len=4 in IDLE -> the next 4 outputs equal their inputs (fill flushed). Also assert reset during WAIT -> no ram_we and no sample_valid for that sample.
